cim_macro_seq: RTL and testbench

- Parametrised successor to the fixed 16x16 compute-in-memory bitcell macro.
- A single sequencer that accepts WRITE, READ and MAC requests over a valid/ready handshake.
- Generates the macro phase strobes (write wordline, precharge, read wordline, sense-enable) and holds a cycle-accurate behavioural array of the stored bits.
- Returns the sense-amp word (READ) or saturated per-column ADC codes (MAC) over a response handshake. Sits between the host controller and the analog macro.

---
 rtl/cim_pkg.sv | 24 ++
 rtl/cim_col_adc.sv | 29 ++
 rtl/cim_macro_seq.sv | 214 +++++++++++++++++++++
 tb/tb_cim_macro_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared encodings for the compute-in-memory macro sequencer: request opcodes,
// sequencer states and the ADC saturation limit.
package cim_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_MAC   = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_PRE,
    S_EVAL,
    S_SENSE,
    S_DONE
  } state_e;

  // Largest code an ADC_BITS-wide converter can report.
  function automatic int sat_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/cim_col_adc.sv
// One bitline column: counts rows where the stored bit and the activation are
// both set, then clamps the count to the ADC full-scale code.
module cim_col_adc
  import cim_pkg::*;
#(
  parameter int ROWS     = 16,
  parameter int ADC_BITS = 4
) (
  input  logic [ROWS-1:0]     col_bits,
  input  logic [ROWS-1:0]     act,
  output logic [ADC_BITS-1:0] code
);

  localparam int CW  = $clog2(ROWS + 1);
  localparam int LIM = sat_max(ADC_BITS);

  logic [CW-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int r = 0; r < ROWS; r++) begin
      cnt = cnt + CW'(col_bits[r] & act[r]);
    end
    // Clamp rather than truncate so a full column never wraps to a small code.
    if (int'(cnt) > LIM) code = ADC_BITS'(LIM);
    else                 code = ADC_BITS'(cnt);
  end

endmodule

// File: rtl/cim_macro_seq.sv
// Request sequencer for the CIM bitcell macro: drives registered phase strobes,
// models the stored array and returns READ words or saturated MAC codes.
module cim_macro_seq
  import cim_pkg::*;
#(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int ADC_BITS = 4,
  parameter int PRE_CYC  = 2,
  parameter int EVAL_CYC = 1,
  parameter int AW       = $clog2(ROWS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [1:0]               REQ_OP,
  input  logic [AW-1:0]            REQ_ADDR,
  input  logic [COLS-1:0]          REQ_DATA,
  input  logic [ROWS-1:0]          REQ_ACT,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic                     RSP_ERR,
  output logic [COLS-1:0]          RSP_SA,
  output logic [COLS*ADC_BITS-1:0] RSP_ADC,
  output logic [ROWS-1:0]          WWL,
  output logic [ROWS-1:0]          RWL,
  output logic                     WE,
  output logic                     PRE_SRAM,
  output logic                     SAEN,
  output logic                     BUSY
);

  localparam int PW   = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
  localparam int CNTW = $clog2(PW + 1);

  typedef struct packed {
    logic [1:0]      op;
    logic [AW-1:0]   addr;
    logic [COLS-1:0] data;
    logic [ROWS-1:0] act;
  } req_t;

  state_e                    state_q, state_d;
  req_t                      req_q, req_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic [ROWS-1:0][COLS-1:0] mem_q, mem_d;
  logic                      req_ready_q, req_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [COLS-1:0]           rsp_sa_q, rsp_sa_d;
  logic [COLS*ADC_BITS-1:0]  rsp_adc_q, rsp_adc_d;
  logic [ROWS-1:0]           wwl_q, wwl_d, rwl_q, rwl_d;
  logic                      we_q, we_d, pre_q, pre_d, saen_q, saen_d;
  logic                      busy_q, busy_d;
  logic                      bad;

  logic [COLS-1:0][ROWS-1:0]     col_bits;
  logic [COLS-1:0][ADC_BITS-1:0] codes;

  function automatic logic [ROWS-1:0] onehot(input logic [AW-1:0] a);
    return ROWS'(1) << a;
  endfunction

  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign col_bits[c][r] = mem_q[r][c];
    end
    cim_col_adc #(
      .ROWS    (ROWS),
      .ADC_BITS(ADC_BITS)
    ) u_adc (
      .col_bits(col_bits[c]),
      .act     (req_q.act),
      .code    (codes[c])
    );
  end

  // Strobes are computed for the state being entered, so every pin is a flop.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    mem_d       = mem_q;
    req_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_sa_d    = rsp_sa_q;
    rsp_adc_d   = rsp_adc_q;
    wwl_d       = '0;
    rwl_d       = '0;
    we_d        = 1'b0;
    pre_d       = 1'b0;
    saen_d      = 1'b0;
    bad         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (REQ_VALID) begin
          req_ready_d = 1'b0;
          req_d       = '{op: REQ_OP, addr: REQ_ADDR, data: REQ_DATA, act: REQ_ACT};
          bad = (REQ_OP == OP_RSVD) || ((REQ_OP != OP_MAC) && (32'(REQ_ADDR) >= ROWS));
          if (bad) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_sa_d    = '0;
            rsp_adc_d   = '0;
          end else if (REQ_OP == OP_WRITE) begin
            state_d = S_WR;
            we_d    = 1'b1;
            wwl_d   = onehot(REQ_ADDR);
          end else begin
            state_d = S_PRE;
            pre_d   = 1'b1;
            cnt_d   = CNTW'(PRE_CYC - 1);
          end
        end
      end
      S_WR: begin
        mem_d[req_q.addr] = req_q.data;
        state_d     = S_DONE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_sa_d    = '0;
        rsp_adc_d   = '0;
      end
      S_PRE: begin
        if (cnt_q == '0) begin
          state_d = S_EVAL;
          rwl_d   = (req_q.op == OP_MAC) ? req_q.act : onehot(req_q.addr);
          cnt_d   = CNTW'(EVAL_CYC - 1);
        end else begin
          pre_d = 1'b1;
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_EVAL: begin
        if (cnt_q == '0) begin
          state_d = S_SENSE;
          saen_d  = 1'b1;
        end else begin
          rwl_d = rwl_q;
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_SENSE: begin
        state_d     = S_DONE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_sa_d    = (req_q.op == OP_READ) ? mem_q[req_q.addr] : '0;
        rsp_adc_d   = (req_q.op == OP_MAC) ? codes : '0;
      end
      S_DONE: begin
        if (RSP_READY) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      mem_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_sa_q    <= '0;
      rsp_adc_q   <= '0;
      wwl_q       <= '0;
      rwl_q       <= '0;
      we_q        <= 1'b0;
      pre_q       <= 1'b0;
      saen_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_sa_q    <= rsp_sa_d;
      rsp_adc_q   <= rsp_adc_d;
      wwl_q       <= wwl_d;
      rwl_q       <= rwl_d;
      we_q        <= we_d;
      pre_q       <= pre_d;
      saen_q      <= saen_d;
      busy_q      <= busy_d;
    end
  end

  assign REQ_READY = req_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ERR   = rsp_err_q;
  assign RSP_SA    = rsp_sa_q;
  assign RSP_ADC   = rsp_adc_q;
  assign WWL       = wwl_q;
  assign RWL       = rwl_q;
  assign WE        = we_q;
  assign PRE_SRAM  = pre_q;
  assign SAEN      = saen_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_cim_macro_seq.sv
// Scoreboarded bench: a default-size macro under directed and random traffic,
// plus a 12-row instance for address errors and a resized instance for timing/saturation.
module tb_cim_macro_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  int   cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- default-size DUT ----------------
  logic        req_valid = 1'b0, rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err, we, pre, saen, busy;
  logic [1:0]  req_op = '0;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_data = '0, req_act = '0;
  logic [15:0] rsp_sa, wwl, rwl;
  logic [63:0] rsp_adc;

  cim_macro_seq dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_OP(req_op),
    .REQ_ADDR(req_addr), .REQ_DATA(req_data), .REQ_ACT(req_act), .RSP_VALID(rsp_valid),
    .RSP_READY(rsp_ready), .RSP_ERR(rsp_err), .RSP_SA(rsp_sa), .RSP_ADC(rsp_adc), .WWL(wwl),
    .RWL(rwl), .WE(we), .PRE_SRAM(pre), .SAEN(saen), .BUSY(busy)
  );

  // ---------------- 12-row DUT ----------------
  logic        e_req_valid = 1'b0, e_rsp_ready = 1'b1;
  logic        e_req_ready, e_rsp_valid, e_rsp_err, e_we, e_pre, e_saen, e_busy;
  logic [1:0]  e_op = '0;
  logic [3:0]  e_addr = '0;
  logic [15:0] e_data = '0, e_rsp_sa;
  logic [11:0] e_act = '0, e_wwl, e_rwl;
  logic [63:0] e_rsp_adc;

  cim_macro_seq #(.ROWS(12)) dut_e (
    .CLK(clk), .RST(rst), .REQ_VALID(e_req_valid), .REQ_READY(e_req_ready), .REQ_OP(e_op),
    .REQ_ADDR(e_addr), .REQ_DATA(e_data), .REQ_ACT(e_act), .RSP_VALID(e_rsp_valid),
    .RSP_READY(e_rsp_ready), .RSP_ERR(e_rsp_err), .RSP_SA(e_rsp_sa), .RSP_ADC(e_rsp_adc),
    .WWL(e_wwl), .RWL(e_rwl), .WE(e_we), .PRE_SRAM(e_pre), .SAEN(e_saen), .BUSY(e_busy)
  );

  // ---------------- resized DUT ----------------
  logic        p_req_valid = 1'b0, p_rsp_ready = 1'b1;
  logic        p_req_ready, p_rsp_valid, p_rsp_err, p_we, p_pre, p_saen, p_busy;
  logic [1:0]  p_op = '0;
  logic [4:0]  p_addr = '0;
  logic [7:0]  p_data = '0, p_rsp_sa;
  logic [31:0] p_act = '0, p_wwl, p_rwl;
  logic [23:0] p_rsp_adc;

  cim_macro_seq #(.ROWS(32), .COLS(8), .ADC_BITS(3), .PRE_CYC(3), .EVAL_CYC(2)) dut_p (
    .CLK(clk), .RST(rst), .REQ_VALID(p_req_valid), .REQ_READY(p_req_ready), .REQ_OP(p_op),
    .REQ_ADDR(p_addr), .REQ_DATA(p_data), .REQ_ACT(p_act), .RSP_VALID(p_rsp_valid),
    .RSP_READY(p_rsp_ready), .RSP_ERR(p_rsp_err), .RSP_SA(p_rsp_sa), .RSP_ADC(p_rsp_adc),
    .WWL(p_wwl), .RWL(p_rwl), .WE(p_we), .PRE_SRAM(p_pre), .SAEN(p_saen), .BUSY(p_busy)
  );

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic        err;
    logic [15:0] sa;
    logic [63:0] adc;
    int          t;
    int          lat;
  } exp_t;

  logic [15:0] mdl [16];
  exp_t        exp_q[$];

  task automatic issue(input logic [1:0] op, input logic [3:0] addr,
                       input logic [15:0] data, input logic [15:0] act);
    exp_t e;
    int   n = 0;
    int   cnt;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data; req_act = act;
    e.t   = cyc_n;
    e.err = (op == 2'd3);
    e.sa  = '0;
    e.adc = '0;
    e.lat = (op == 2'd3) ? 1 : (op == 2'd0) ? 2 : 5;
    if (op == 2'd0) mdl[addr] = data;
    else if (op == 2'd1) e.sa = mdl[addr];
    else if (op == 2'd2) begin
      for (int c = 0; c < 16; c++) begin
        cnt = 0;
        for (int r = 0; r < 16; r++) if (act[r] && mdl[r][c]) cnt++;
        e.adc[c*4 +: 4] = 4'((cnt > 15) ? 15 : cnt);
      end
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = 4'($urandom);
    req_data = 16'($urandom); req_act = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin @(posedge clk); #1; n++; end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  // 0: always ready, 1: random, 2: stall each response for exactly 4 cycles
  int bp_mode = 0, hold_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = 1'($urandom_range(0, 1));
      default: begin
        if (rsp_valid && hold_cnt < 4) begin rsp_ready = 1'b0; hold_cnt++; end
        else begin rsp_ready = 1'b1; if (!rsp_valid) hold_cnt = 0; end
      end
    endcase
  end

  exp_t        cur;
  logic        hold = 1'b0, after_hs = 1'b0, h_err;
  logic [15:0] h_sa;
  logic [63:0] h_adc;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0; after_hs = 1'b0;
    end else begin
      if (after_hs) chk("req_ready_after_hs", 64'(req_ready), 64'(1));
      after_hs = 1'b0;
      if (rsp_valid) begin
        if (hold) begin
          chk("hold_sa", 64'(rsp_sa), 64'(h_sa));
          chk("hold_adc", rsp_adc, h_adc);
          chk("hold_err", 64'(rsp_err), 64'(h_err));
          chk("hold_req_ready", 64'(req_ready), 64'(0));
        end else if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(exp_q.size()), 64'(1));
        end else begin
          cur = exp_q.pop_front();
          chk("latency", 64'(cyc_n - cur.t), 64'(cur.lat));
          chk("rsp_err", 64'(rsp_err), 64'(cur.err));
          chk("rsp_sa", 64'(rsp_sa), 64'(cur.sa));
          chk("rsp_adc", rsp_adc, cur.adc);
          h_sa = rsp_sa; h_adc = rsp_adc; h_err = rsp_err;
        end
        hold = !rsp_ready;
        after_hs = rsp_ready;
      end
      chk("strobe_excl", 64'(int'(we) + int'(pre) + int'(rwl != 0) + int'(saen) <= 1), 64'(1));
      chk("wwl_shape", 64'(we ? $onehot(wwl) : (wwl == 0)), 64'(1));
    end
  end

  task automatic e_do(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] data,
                      output int lat, output logic [4:0] strb);
    int n = 0;
    while (!e_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    e_req_valid = 1'b1; e_op = op; e_addr = addr; e_data = data;
    @(posedge clk); #1;
    e_req_valid = 1'b0;
    strb = {e_we, e_pre, e_saen, |e_rwl, |e_wwl};
    lat = 1;
    while (!e_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic p_do(input logic [1:0] op, input logic [4:0] addr, input logic [7:0] data,
                      input logic [31:0] act, output int lat);
    int n = 0;
    while (!p_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    p_req_valid = 1'b1; p_op = op; p_addr = addr; p_data = data; p_act = act;
    @(posedge clk); #1;
    p_req_valid = 1'b0;
    lat = 1;
    while (!p_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  initial begin
    int       lat, n;
    logic [4:0] strb;
    for (int r = 0; r < 16; r++) mdl[r] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_sa, busy}, 64'(0));
    chk("rst_adc", rsp_adc, 64'(0));
    chk("rst_strobes", {wwl, rwl, we, pre, saen}, 64'(0));

    // WRITE then READ with phase timing
    issue(2'd0, 4'd3, 16'hA5C3, 16'h0);
    @(negedge clk);
    chk("wr_wwl", 64'(wwl), 64'h0008);
    chk("wr_we", 64'(we), 64'(1));
    issue(2'd1, 4'd3, 16'h0, 16'h0);
    @(negedge clk); chk("rd_pre1", 64'(pre), 64'(1));
    @(negedge clk); chk("rd_pre2", 64'(pre), 64'(1));
    @(negedge clk); chk("rd_rwl", 64'({pre, rwl}), 64'h0008);
    @(negedge clk); chk("rd_saen", 64'(saen), 64'(1));
    drain();

    // MAC saturation and exact counts
    for (int r = 0; r < 16; r++) issue(2'd0, 4'(r), 16'hFFFF, 16'h0);
    issue(2'd2, 4'd0, 16'h0, 16'hFFFF);
    issue(2'd2, 4'd7, 16'h0, 16'h00FF);
    issue(2'd0, 4'd0, 16'h0001, 16'h0);
    issue(2'd2, 4'd9, 16'h0, 16'h0001);
    drain();

    // response backpressure
    bp_mode = 2;
    issue(2'd1, 4'd3, 16'h0, 16'h0);
    drain();
    bp_mode = 0;

    // reserved op
    issue(2'd3, 4'd0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rsvd_strobes", {wwl, rwl, we, pre, saen}, 64'(0));
    drain();

    // reset while the MAC is in its evaluation phase
    issue(2'd2, 4'd0, 16'h0, 16'hFFFF);
    n = 0;
    @(negedge clk);
    while (rwl == 0 && n < 20) begin @(negedge clk); n++; end
    chk("mac_eval_seen", 64'(rwl), 64'hFFFF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    for (int r = 0; r < 16; r++) mdl[r] = '0;
    @(negedge clk);
    chk("midrst_state", {busy, rsp_valid, wwl, rwl, we, pre, saen}, 64'(0));
    issue(2'd1, 4'd0, 16'h0, 16'h0);
    drain();

    // random traffic with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 80; i++)
      issue(2'($urandom_range(0, 3)), 4'($urandom), 16'($urandom), 16'($urandom));
    drain();
    bp_mode = 0;

    // 12-row instance: out-of-range addresses
    e_do(2'd0, 4'd13, 16'hFFFF, lat, strb);
    chk("e_wr13_err", 64'(e_rsp_err), 64'(1));
    chk("e_wr13_lat", 64'(lat), 64'(1));
    chk("e_wr13_strb", 64'(strb), 64'(0));
    e_do(2'd1, 4'd13, 16'h0, lat, strb);
    chk("e_rd13_err", 64'(e_rsp_err), 64'(1));
    chk("e_rd13_lat", 64'(lat), 64'(1));
    chk("e_rd13_data", {e_rsp_sa, e_rsp_adc[47:0]}, 64'(0));
    chk("e_rd13_strb", 64'(strb), 64'(0));
    e_do(2'd1, 4'd5, 16'h0, lat, strb);
    chk("e_rd5", {47'(0), e_rsp_err, e_rsp_sa}, 64'(0));
    chk("e_rd5_lat", 64'(lat), 64'(5));
    e_do(2'd0, 4'd11, 16'h1234, lat, strb);
    e_do(2'd1, 4'd11, 16'h0, lat, strb);
    chk("e_rd11", {47'(0), e_rsp_err, e_rsp_sa}, 64'h1234);

    // resized instance: latency and 3-bit saturation
    for (int r = 0; r < 9; r++) begin
      p_do(2'd0, 5'(r), 8'hFF, 32'h0, lat);
      if (r == 0) chk("p_wr_lat", 64'(lat), 64'(2));
    end
    p_do(2'd1, 5'd0, 8'h0, 32'h0, lat);
    chk("p_rd_lat", 64'(lat), 64'(7));
    chk("p_rd_sa", {p_rsp_err, p_rsp_sa}, 64'h0FF);
    p_do(2'd2, 5'd31, 8'h0, 32'h0000_003F, lat);
    chk("p_mac6_lat", 64'(lat), 64'(7));
    chk("p_mac6", 64'(p_rsp_adc), 64'({8{3'd6}}));
    p_do(2'd2, 5'd4, 8'h0, 32'h0000_01FF, lat);
    chk("p_mac9", 64'(p_rsp_adc), 64'({8{3'd7}}));
    p_do(2'd2, 5'd4, 8'h0, 32'hFFFF_FE00, lat);
    chk("p_mac0", 64'(p_rsp_adc), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("idle_all", {p_busy, e_busy}, 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
